// File: rtl/riscv_dmem_responder_pkg.sv
`default_nettype none
//------------------------------------------------------------------------
// riscv_dmem_responder_pkg: shared encodings and lane helpers for dmem
// Rev 1.0
//------------------------------------------------------------------------
package riscv_dmem_responder_pkg;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  // Encoding 3 is not a distinct size; it behaves exactly like a word.
  typedef enum logic [1:0] {
    LEN_WORD     = 2'd0,
    LEN_BYTE     = 2'd1,
    LEN_HALF     = 2'd2,
    LEN_WORD_ALT = 2'd3
  } len_e;

  localparam int RESP_RW_W   = 1;
  localparam int RESP_LEN_W  = 2;
  localparam int RESP_DATA_W = 32;
  localparam int RESP_MSG_W  = RESP_RW_W + RESP_LEN_W + RESP_DATA_W;

  typedef struct packed {
    logic [RESP_RW_W-1:0]   rw;
    logic [RESP_LEN_W-1:0]  len;
    logic [RESP_DATA_W-1:0] data;
  } resp_msg_t;

  // Lanes that fall off the top of the word are dropped by the 4-bit shift.
  function automatic logic [3:0] lane_enables(input logic [1:0] len, input logic [1:0] off);
    logic [3:0] base;
    case (len)
      LEN_BYTE: base = 4'b0001;
      LEN_HALF: base = 4'b0011;
      default:  base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] len,
                                               input logic [1:0] off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (len)
      LEN_BYTE: return {24'h0, shifted[7:0]};
      LEN_HALF: return {16'h0, shifted[15:0]};
      default:  return shifted;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------
// riscv_dmem_responder_if: core-to-dmem val/rdy request/response bundle
// Rev 1.0
//------------------------------------------------------------------------
interface riscv_dmem_responder_if;
  import riscv_dmem_responder_pkg::*;

  logic                   memreq_val;
  logic                   memreq_rdy;
  logic                   memreq_msg_rw;
  logic [RESP_LEN_W-1:0]  memreq_msg_len;
  logic [31:0]            memreq_msg_addr;
  logic [RESP_DATA_W-1:0] memreq_msg_data;

  logic                   memresp_val;
  logic                   memresp_rdy;
  logic                   memresp_msg_rw;
  logic [RESP_LEN_W-1:0]  memresp_msg_len;
  logic [RESP_DATA_W-1:0] memresp_msg_data;

  modport master (
    output memreq_val, memreq_msg_rw, memreq_msg_len, memreq_msg_addr, memreq_msg_data,
    output memresp_rdy,
    input  memreq_rdy,
    input  memresp_val, memresp_msg_rw, memresp_msg_len, memresp_msg_data
  );

  modport slave (
    input  memreq_val, memreq_msg_rw, memreq_msg_len, memreq_msg_addr, memreq_msg_data,
    input  memresp_rdy,
    output memreq_rdy,
    output memresp_val, memresp_msg_rw, memresp_msg_len, memresp_msg_data
  );

endinterface
`default_nettype wire

// File: rtl/riscv_dmem_resp_queue.sv
`default_nettype none
//------------------------------------------------------------------------
// riscv_dmem_resp_queue: circular val/rdy FIFO; the producer bounds occupancy
// Rev 1.0
//------------------------------------------------------------------------
module riscv_dmem_resp_queue
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = RESP_MSG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_bits
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             deq_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign deq_val  = (count_q != '0);
  assign deq_bits = entries_q[rd_ptr_q];
  assign deq_fire = deq_val && deq_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_val)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq_val, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_val) entries_q[wr_ptr_q] <= enq_bits;
  end

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_responder.sv
`default_nettype none
//------------------------------------------------------------------------
// riscv_dmem_responder: byte-lane data memory answering in order after LATENCY
// Rev 1.0
//------------------------------------------------------------------------
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int SIZE_BYTES  = 65536,
  parameter int LATENCY     = 1,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_dmem_responder_if.slave dmem
);

  localparam int ADDR_W = $clog2(SIZE_BYTES);
  localparam int WORDS  = SIZE_BYTES / 4;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int STAGES = LATENCY - 1;

  logic [31:0]           mem_q [WORDS];
  logic                  req_fire;
  logic                  resp_fire;
  logic [ADDR_W-3:0]     word_idx;
  logic [1:0]            byte_off;
  logic [3:0]            lane_en;
  logic [31:0]           wdata;
  resp_msg_t             acc_msg;
  resp_msg_t             deq_msg;
  logic                  enq_val;
  logic [RESP_MSG_W-1:0] enq_bits;
  logic [RESP_MSG_W-1:0] deq_bits;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^dmem.memreq_msg_addr[31:ADDR_W];

  // Outstanding count covers both pipeline stages and queue, so the queue can never overflow.
  assign dmem.memreq_rdy = !reset && (cnt_q < CNT_W'(QUEUE_DEPTH));
  assign req_fire        = dmem.memreq_val && dmem.memreq_rdy;
  assign resp_fire       = dmem.memresp_val && dmem.memresp_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (req_fire && !resp_fire)      cnt_d = cnt_q + CNT_W'(1);
    else if (!req_fire && resp_fire) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign word_idx = dmem.memreq_msg_addr[ADDR_W-1:2];
  assign byte_off = dmem.memreq_msg_addr[1:0];
  assign lane_en  = lane_enables(dmem.memreq_msg_len, byte_off);
  assign wdata    = dmem.memreq_msg_data << {byte_off, 3'b000};

  always_ff @(posedge clk) begin
    if (req_fire && (dmem.memreq_msg_rw == RW_WRITE)) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Load data is captured at accept time so later stores cannot leak into it.
  always_comb begin
    acc_msg      = '0;
    acc_msg.rw   = dmem.memreq_msg_rw;
    acc_msg.len  = dmem.memreq_msg_len;
    if (dmem.memreq_msg_rw == RW_READ)
      acc_msg.data = load_extract(mem_q[word_idx], dmem.memreq_msg_len, byte_off);
  end

  generate
    if (STAGES == 0) begin : g_direct
      assign enq_val  = req_fire;
      assign enq_bits = acc_msg;
    end else begin : g_pipe
      logic [STAGES-1:0] val_q, val_d;
      resp_msg_t         bits_q [STAGES];
      resp_msg_t         bits_d [STAGES];

      always_comb begin
        val_d[0]  = req_fire;
        bits_d[0] = acc_msg;
        for (int s = 1; s < STAGES; s++) begin
          val_d[s]  = val_q[s-1];
          bits_d[s] = bits_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) val_q <= '0;
        else       val_q <= val_d;
      end

      always_ff @(posedge clk) begin
        bits_q <= bits_d;
      end

      assign enq_val  = val_q[STAGES-1];
      assign enq_bits = bits_q[STAGES-1];
    end
  endgenerate

  riscv_dmem_resp_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (RESP_MSG_W)
  ) u_resp_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (enq_val),
    .enq_bits (enq_bits),
    .deq_val  (dmem.memresp_val),
    .deq_rdy  (dmem.memresp_rdy),
    .deq_bits (deq_bits)
  );

  assign deq_msg               = deq_bits;
  assign dmem.memresp_msg_rw   = deq_msg.rw;
  assign dmem.memresp_msg_len  = deq_msg.len;
  assign dmem.memresp_msg_data = deq_msg.data;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
`default_nettype none
//------------------------------------------------------------------------
// tb_riscv_dmem_responder: two responders (LATENCY 1 and 3) against a byte-level model
// Rev 1.0
//------------------------------------------------------------------------
module tb_riscv_dmem_responder;
  import riscv_dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_dmem_responder_if if_a ();
  riscv_dmem_responder_if if_b ();

  riscv_dmem_responder #(.SIZE_BYTES(65536), .LATENCY(1), .QUEUE_DEPTH(2))
    dut_a (.clk(clk), .reset(reset), .dmem(if_a));
  riscv_dmem_responder #(.SIZE_BYTES(65536), .LATENCY(3), .QUEUE_DEPTH(2))
    dut_b (.clk(clk), .reset(reset), .dmem(if_b));

  bit          sel;
  logic        req_val, req_rw, resp_rdy;
  logic [1:0]  req_len;
  logic [31:0] req_addr, req_data;

  assign if_a.memreq_val      = !sel && req_val;
  assign if_b.memreq_val      = sel && req_val;
  assign if_a.memresp_rdy     = sel ? 1'b1 : resp_rdy;
  assign if_b.memresp_rdy     = sel ? resp_rdy : 1'b1;
  assign if_a.memreq_msg_rw   = req_rw;
  assign if_b.memreq_msg_rw   = req_rw;
  assign if_a.memreq_msg_len  = req_len;
  assign if_b.memreq_msg_len  = req_len;
  assign if_a.memreq_msg_addr = req_addr;
  assign if_b.memreq_msg_addr = req_addr;
  assign if_a.memreq_msg_data = req_data;
  assign if_b.memreq_msg_data = req_data;

  logic        o_req_rdy, o_resp_val, o_resp_rw;
  logic [1:0]  o_resp_len;
  logic [31:0] o_resp_data;
  assign o_req_rdy   = sel ? if_b.memreq_rdy       : if_a.memreq_rdy;
  assign o_resp_val  = sel ? if_b.memresp_val      : if_a.memresp_val;
  assign o_resp_rw   = sel ? if_b.memresp_msg_rw   : if_a.memresp_msg_rw;
  assign o_resp_len  = sel ? if_b.memresp_msg_len  : if_a.memresp_msg_len;
  assign o_resp_data = sel ? if_b.memresp_msg_data : if_a.memresp_msg_data;

  typedef struct {
    logic        rw;
    logic [1:0]  len;
    logic [31:0] data;
    int          ready;
  } exp_t;
  typedef struct {
    logic [31:0] data;
    int          c;
  } got_t;

  exp_t       exp_q[$];
  got_t       got_log[$];
  int         acc_log[$];
  logic [7:0] mem_m [2][65536];
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  bit         chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  task automatic bound_fail(input string nm);
    total++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] gd(input int i);
    if (i < got_log.size()) return got_log[i].data;
    return 32'hBAD0BAD0;
  endfunction
  function automatic int gc(input int i);
    if (i < got_log.size()) return got_log[i].c;
    return -1000;
  endfunction
  function automatic int ac(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 1000;
  endfunction

  // Model: a response becomes visible LATENCY cycles after its accept cycle, oldest first.
  always @(posedge clk) begin
    bit   m_rdy, m_val;
    int   lat, base, off, n, d;
    exp_t e;
    got_t g;
    d     = sel ? 1 : 0;
    lat   = sel ? 3 : 1;
    m_rdy = !reset && (exp_q.size() < 2);
    m_val = (exp_q.size() != 0) && (exp_q[0].ready <= cyc);
    if (req_val && o_req_rdy) acc_log.push_back(cyc);
    if (o_resp_val && resp_rdy) begin
      g.data = o_resp_data;
      g.c    = cyc;
      got_log.push_back(g);
    end
    if (reset) begin
      exp_q.delete();
    end else begin
      if (m_val && resp_rdy) void'(exp_q.pop_front());
      if (req_val && m_rdy) begin
        base    = int'(req_addr[15:0]) & 32'hFFFC;
        off     = int'(req_addr[1:0]);
        n       = (req_len == 2'd1) ? 1 : (req_len == 2'd2) ? 2 : 4;
        e.rw    = req_rw;
        e.len   = req_len;
        e.data  = 32'h0;
        e.ready = cyc + lat;
        for (int k = 0; k < n; k++) begin
          if (off + k < 4) begin
            if (req_rw) mem_m[d][base + off + k] = req_data[8*k +: 8];
            else        e.data[8*k +: 8]          = mem_m[d][base + off + k];
          end
        end
        exp_q.push_back(e);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit e_rdy, e_val;
    if (chk_en) begin
      e_rdy = !reset && (exp_q.size() < 2);
      e_val = (exp_q.size() != 0) && (exp_q[0].ready <= cyc);
      check("memreq_rdy", 32'(o_req_rdy), 32'(e_rdy));
      check("memresp_val", 32'(o_resp_val), 32'(e_val));
      if (e_val && o_resp_val) begin
        check("memresp_data", o_resp_data, exp_q[0].data);
        check("memresp_rw", 32'(o_resp_rw), 32'(exp_q[0].rw));
        check("memresp_len", 32'(o_resp_len), 32'(exp_q[0].len));
      end
    end
  end

  task automatic send(input logic rw, input logic [1:0] len, input logic [31:0] addr,
                      input logic [31:0] data);
    bit done;
    int n;
    req_val = 1'b1; req_rw = rw; req_len = len; req_addr = addr; req_data = data;
    done = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      done = o_req_rdy;
      @(posedge clk); #1;
      n++;
    end
    req_val = 1'b0;
    if (!done) bound_fail("send_accept");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) bound_fail("drain");
  endtask

  task automatic clear_logs();
    acc_log.delete();
    got_log.delete();
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; req_val = 1'b0; req_rw = 1'b0; req_len = 2'd0;
    req_addr = 32'h0; req_data = 32'h0; resp_rdy = 1'b1;
    dut_a.mem_q[14'h0C00] = 32'hCAFEF00D;
    mem_m[0][16'h3000] = 8'h0D; mem_m[0][16'h3001] = 8'hF0;
    mem_m[0][16'h3002] = 8'hFE; mem_m[0][16'h3003] = 8'hCA;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_req_rdy", 32'(o_req_rdy), 32'h0);
    check("reset_resp_val", 32'(o_resp_val), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Word write then word read, LATENCY 1
    clear_logs();
    send(RW_WRITE, LEN_WORD, 32'h2000, 32'hDEADBEEF);
    send(RW_READ,  LEN_WORD, 32'h2000, 32'h0);
    drain();
    check("t1_wr_data", gd(0), 32'h0);
    check("t1_rd_data", gd(1), 32'hDEADBEEF);
    check("t1_wr_lat", 32'(gc(0) - ac(0)), 32'd1);
    check("t1_rd_lat", 32'(gc(1) - ac(1)), 32'd1);

    // Sub-word stores and loads, including misaligned ones
    clear_logs();
    send(RW_WRITE, LEN_BYTE, 32'h2001, 32'h000000AA);
    send(RW_WRITE, LEN_HALF, 32'h2002, 32'h00001234);
    send(RW_READ,  LEN_WORD, 32'h2000, 32'h0);
    send(RW_READ,  LEN_BYTE, 32'h2003, 32'h0);
    send(RW_READ,  LEN_HALF, 32'h2000, 32'h0);
    send(RW_WRITE, LEN_HALF, 32'h2003, 32'h00005566);
    send(RW_READ,  LEN_WORD, 32'h2000, 32'h0);
    send(RW_READ,  LEN_WORD, 32'h2001, 32'h0);
    send(RW_READ,  LEN_WORD_ALT, 32'h3000, 32'h0);
    drain();
    check("t2_word", gd(2), 32'h1234AAEF);
    check("t2_byte", gd(3), 32'h00000012);
    check("t2_half", gd(4), 32'h0000AAEF);
    check("t2_mis_half_wr", gd(6), 32'h6634AAEF);
    check("t2_mis_word_rd", gd(7), 32'h006634AA);
    check("t2_preload", gd(8), 32'hCAFEF00D);

    // LATENCY 3, back-to-back reads
    sel = 1'b1;
    send(RW_WRITE, LEN_WORD, 32'h0100, 32'h11223344);
    send(RW_WRITE, LEN_WORD, 32'h0104, 32'h55667788);
    drain();
    clear_logs();
    send(RW_READ, LEN_WORD, 32'h0100, 32'h0);
    send(RW_READ, LEN_WORD, 32'h0104, 32'h0);
    drain();
    check("t3_b2b_accept", 32'(ac(1) - ac(0)), 32'd1);
    check("t3_lat0", 32'(gc(0) - ac(0)), 32'd3);
    check("t3_lat1", 32'(gc(1) - ac(1)), 32'd3);
    check("t3_data0", gd(0), 32'h11223344);
    check("t3_data1", gd(1), 32'h55667788);
    sel = 1'b0;
    @(posedge clk); #1;

    // Response-side stall fills the queue and back-pressures requests
    clear_logs();
    resp_rdy = 1'b0;
    send(RW_READ, LEN_WORD, 32'h2000, 32'h0);
    send(RW_READ, LEN_WORD, 32'h3000, 32'h0);
    req_val = 1'b1; req_rw = RW_READ; req_len = LEN_HALF; req_addr = 32'h2002; req_data = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t4_full_req_rdy", 32'(o_req_rdy), 32'h0);
    check("t4_full_resp_val", 32'(o_resp_val), 32'h1);
    @(posedge clk); #1 resp_rdy = 1'b1;
    @(posedge clk); #1 resp_rdy = 1'b0;
    @(negedge clk);
    check("t4_reopen_req_rdy", 32'(o_req_rdy), 32'h1);
    @(posedge clk); #1 req_val = 1'b0;
    resp_rdy = 1'b1;
    drain();
    check("t4_n_resp", 32'(got_log.size()), 32'd3);
    check("t4_data0", gd(0), 32'h6634AAEF);
    check("t4_data1", gd(1), 32'hCAFEF00D);
    check("t4_data2", gd(2), 32'h00006634);

    // Accept and dequeue in the same cycle at cnt = 1
    clear_logs();
    send(RW_READ, LEN_BYTE, 32'h3001, 32'h0);
    send(RW_READ, LEN_BYTE, 32'h3002, 32'h0);
    @(negedge clk);
    check("t5_cnt_hold", 32'(dut_a.cnt_q), 32'd1);
    check("t5_req_rdy", 32'(o_req_rdy), 32'h1);
    drain();
    check("t5_data0", gd(0), 32'h000000F0);
    check("t5_data1", gd(1), 32'h000000FE);

    // Reset with two responses queued; committed write survives
    resp_rdy = 1'b0;
    send(RW_WRITE, LEN_WORD, 32'h0400, 32'h0BADF00D);
    send(RW_READ,  LEN_WORD, 32'h2000, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_reset_resp_val", 32'(o_resp_val), 32'h0);
    check("t6_reset_req_rdy", 32'(o_req_rdy), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    resp_rdy = 1'b1;
    clear_logs();
    send(RW_READ, LEN_WORD, 32'h0400, 32'h0);
    drain();
    check("t6_n_resp", 32'(got_log.size()), 32'd1);
    check("t6_kept_write", gd(0), 32'h0BADF00D);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
